// File: rtl/instr_loader_if.sv
// instr_loader_if: byte-stream input and instruction-memory write bus of the loader
interface instr_loader_if;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  modport master(output in_data, in_valid, input in_ready, mem_we, mem_addr, mem_wd);
  modport slave(input in_data, in_valid, output in_ready, mem_we, mem_addr, mem_wd);
endinterface

// File: rtl/instr_loader.sv
// instr_loader: parses a counted, checksummed byte stream into 32-bit instruction-memory writes
module instr_loader #(
  parameter int          DEPTH = 1024,
  parameter logic [31:0] BASE  = 32'h00000000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  instr_loader_if.slave bus,
  output logic          core_rst_n,
  output logic          done,
  output logic          err
);
  typedef enum logic [2:0] {HDR0, HDR1, DATA, CHK, DONE, ERR} state_t;
  state_t      r_state, w_next;
  logic [15:0] r_n, r_wcnt, w_n;
  logic [1:0]  r_lane;
  logic [7:0]  r_sum;
  logic [23:0] r_word;
  logic        r_we;
  logic [31:0] r_addr, r_wd;
  logic        w_acc, w_restart;
  // Status outputs decode straight from the state; the loader never stalls inside a frame
  always_comb begin
    bus.in_ready = r_state != DONE && r_state != ERR;
    bus.mem_we   = r_we;
    bus.mem_addr = r_addr;
    bus.mem_wd   = r_wd;
    core_rst_n   = r_state == DONE;
    done         = r_state == DONE;
    err          = r_state == ERR;
    w_acc        = bus.in_valid && bus.in_ready;
    w_restart    = start && (r_state == DONE || r_state == ERR);
    w_n          = {bus.in_data, r_n[7:0]};
  end
  // Next-state: header, data and checksum phases each advance only on accepted bytes
  always_comb begin
    w_next = r_state;
    case (r_state)
      HDR0: w_next = w_acc ? HDR1 : HDR0;
      HDR1: if (w_acc) w_next = (w_n == 16'd0) ? CHK : ({16'd0, w_n} > 32'(DEPTH)) ? ERR : DATA;
      DATA: if (w_acc && r_lane == 2'd3 && r_wcnt == r_n - 16'd1) w_next = CHK;
      CHK:  if (w_acc) w_next = (bus.in_data == r_sum) ? DONE : ERR;
      default: w_next = w_restart ? HDR0 : r_state;
    endcase
  end
  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= HDR0;
    else r_state <= w_next;
  end
  // Datapath: header capture, little-endian word assembly, checksum and the registered write
  always_ff @(posedge clk) begin
    if (rst) begin
      r_n    <= '0;
      r_wcnt <= '0;
      r_lane <= '0;
      r_sum  <= '0;
      r_word <= '0;
      r_we   <= 1'b0;
      r_addr <= BASE;
      r_wd   <= '0;
    end else begin
      r_we <= 1'b0;
      if (w_restart) begin
        r_wcnt <= '0;
        r_lane <= '0;
        r_sum  <= '0;
      end
      if (w_acc && r_state == HDR0) r_n[7:0] <= bus.in_data;
      if (w_acc && r_state == HDR1) r_n[15:8] <= bus.in_data;
      if (w_acc && r_state == DATA) begin
        r_sum  <= r_sum + bus.in_data;
        r_lane <= r_lane + 2'd1;
        r_word <= {bus.in_data, r_word[23:8]};
        if (r_lane == 2'd3) begin
          r_we   <= 1'b1;
          r_wd   <= {bus.in_data, r_word};
          r_addr <= BASE + {14'd0, r_wcnt, 2'b00};
          r_wcnt <= r_wcnt + 16'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_instr_loader.sv
// tb_instr_loader: randomized frames against a frame-level model, writes checked by a scoreboard monitor
module tb_instr_loader;
  logic clk = 1'b0;
  logic rst, start, core_rst_n, done, err;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] exp_q[$];
  instr_loader_if bus();
  instr_loader #(.DEPTH(1024), .BASE(32'h00000000)) dut (
    .clk(clk), .rst(rst), .start(start), .bus(bus.slave),
    .core_rst_n(core_rst_n), .done(done), .err(err)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_write actual=%h:%h expected=none", bus.mem_addr, bus.mem_wd);
      end else begin
        logic [63:0] e;
        e = exp_q.pop_front();
        chk("write_addr", bus.mem_addr, e[63:32]);
        chk("write_data", bus.mem_wd, e[31:0]);
      end
    end
  end
  task automatic send(input logic [7:0] b, input int gap);
    repeat (gap) begin
      bus.in_valid = 1'b0;
      @(posedge clk); #1;
    end
    if (bus.in_ready !== 1'b1) begin
      chk("in_ready_in_frame", {31'd0, bus.in_ready}, 32'd1);
      return;
    end
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    start        = ($urandom_range(0, 7) == 0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    start        = 1'b0;
  endtask
  task automatic restart();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("restart_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    chk("restart_in_ready", {31'd0, bus.in_ready}, 32'd1);
  endtask
  task automatic frame(input logic [31:0] ws[$], input int gap, input bit bad);
    logic [7:0]  sum = 8'd0;
    logic [15:0] n = 16'(ws.size());
    send(n[7:0], $urandom_range(0, gap));
    send(n[15:8], $urandom_range(0, gap));
    for (int k = 0; k < ws.size(); k++) begin
      exp_q.push_back({32'(4 * k), ws[k]});
      for (int b = 0; b < 4; b++) begin
        logic [31:0] w = ws[k];
        sum = sum + w[8*b +: 8];
        send(w[8*b +: 8], $urandom_range(0, gap));
      end
    end
    send(bad ? sum + 8'd1 : sum, $urandom_range(0, gap));
    repeat (2) @(posedge clk);
    #1;
    chk("frame_done", {31'd0, done}, {31'd0, !bad});
    chk("frame_err", {31'd0, err}, {31'd0, bad});
    chk("frame_core_rst_n", {31'd0, core_rst_n}, {31'd0, !bad});
    chk("frame_in_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("frame_writes_seen", exp_q.size(), 32'd0);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    logic [31:0] ws[$];
    logic [31:0] w0;
    rst = 1'b1; start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_we", {31'd0, bus.mem_we}, 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_wd", bus.mem_wd, 32'd0);
    chk("rst_core_rst_n", {31'd0, core_rst_n}, 32'd0);
    chk("rst_done_err", {30'd0, done, err}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    ws = {32'h0062E233};
    frame(ws, 0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.in_valid = 1'b1; bus.in_data = 8'($urandom);
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    chk("done_ignores_bytes", {30'd0, done, err}, 32'd2);
    restart();
    frame(ws, 0, 1'b1);
    restart();
    ws.delete();
    frame(ws, 0, 1'b0);
    restart();
    send(8'h01, 0);
    send(8'h04, 0);
    chk("oversize_err", {31'd0, err}, 32'd1);
    chk("oversize_in_ready", {31'd0, bus.in_ready}, 32'd0);
    restart();
    ws = {32'($urandom), 32'($urandom), 32'($urandom)};
    frame(ws, 3, 1'b0);
    for (int f = 0; f < 6; f++) begin
      restart();
      ws.delete();
      repeat ($urandom_range(1, 5)) ws.push_back(32'($urandom));
      frame(ws, $urandom_range(0, 2), $urandom_range(0, 2) == 0);
    end
    restart();
    w0 = 32'($urandom);
    send(8'h02, 0);
    send(8'h00, 0);
    exp_q.push_back({32'd0, w0});
    for (int b = 0; b < 4; b++) send(w0[8*b +: 8], 0);
    send(8'($urandom), 0);
    send(8'($urandom), 0);
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 8'h05;
    @(posedge clk); #1;
    rst = 1'b0; bus.in_valid = 1'b0;
    chk("midframe_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    chk("midframe_rst_done_err", {30'd0, done, err}, 32'd0);
    send(8'h01, 0);
    send(8'h00, 0);
    for (int b = 0; b < 3; b++) send(8'($urandom), 0);
    rst = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 8'hAA;
    @(posedge clk); #1;
    rst = 1'b0; bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_drops_pending_word", exp_q.size(), 32'd0);
    ws = {32'($urandom)};
    frame(ws, 1, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Parameters
REQ-001 SHALL have parameter DEPTH, default 1024, meaning the maximum number of 32-bit words the instruction memory accepts.
REQ-002 SHALL have parameter BASE, default 32'h00000000, meaning the byte address of the first word written.

Interface
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port in_data, input, 8 bits: byte from the load stream.
REQ-006 SHALL have port in_valid, input, 1 bit: in_data holds a valid byte.
REQ-007 SHALL have port in_ready, output, 1 bit: the loader accepts a byte; a byte transfers on any edge where in_valid=1 and in_ready=1.
REQ-008 SHALL have port start, input, 1 bit: restart a load from DONE or ERR.
REQ-009 SHALL have port mem_we, output, 1 bit: instruction-memory write strobe, one cycle per word.
REQ-010 SHALL have port mem_addr, output, 32 bits: word-aligned byte address; the memory indexes it with [31:2].
REQ-011 SHALL have port mem_wd, output, 32 bits: write data.
REQ-012 SHALL have port core_rst_n, output, 1 bit: core/instruction-memory reset, active-low; 0 holds the core.
REQ-013 SHALL have port done, output, 1 bit: load completed and verified.
REQ-014 SHALL have port err, output, 1 bit: load failed.

Function
REQ-015 SHALL use the stream format: byte N_lo, byte N_hi (16-bit word count N), then 4*N data bytes, then one checksum byte.
REQ-016 SHALL assemble each group of 4 data bytes little-endian: the first byte goes to [7:0] and the fourth to [31:24].
REQ-017 SHALL implement the FSM states HDR0, HDR1, DATA, CHK, DONE, ERR.
REQ-018 SHALL move HDR0->HDR1 and HDR1->DATA each on one accepted byte.
REQ-019 SHALL, at the exit of HDR1, go to CHK if N=0 and to ERR if N>DEPTH.
REQ-020 SHALL move DATA->CHK after the 4*N-th data byte is accepted.
REQ-021 SHALL, in CHK, go to DONE if the accepted byte equals the 8-bit wrap-around sum of all data bytes (header excluded); otherwise go to ERR.
REQ-022 SHALL hold in_ready=1 in HDR0, HDR1, DATA and CHK, and 0 in DONE and ERR; the loader never stalls inside a frame.
REQ-023 SHALL register the write: the cycle after the 4th byte of word k is accepted, mem_we=1, mem_addr=BASE+4k, mem_wd=the assembled word.
REQ-024 SHALL hold mem_we=0 in all other cycles; mem_addr and mem_wd hold their last values.
REQ-025 SHALL NOT drop a byte accepted in the same cycle as a mem_we pulse.
REQ-026 SHALL use a word counter 16 bits wide and a byte-lane counter 2 bits wide that wraps 3->0.
REQ-027 SHALL hold core_rst_n=0 in every state except DONE, and drive core_rst_n=1 in DONE.
REQ-028 SHALL drive done=1 only in DONE and err=1 only in ERR.
REQ-029 SHALL, when start=1 in DONE or ERR, clear the counters and checksum, go to HDR0 and drive core_rst_n=0 on the next cycle.
REQ-030 SHALL ignore start in all other states.
REQ-031 SHALL ignore in_valid when in_ready=0.
REQ-032 SHALL not time out: an idle stream leaves the FSM in its current state indefinitely.

Reset
REQ-033 SHALL, while rst=1 at a clock edge, set: state=HDR0, counters=0, checksum=0, mem_we=0, mem_addr=BASE, mem_wd=0, core_rst_n=0, done=0, err=0.
REQ-034 SHALL make in_ready=1 on the first edge after rst deasserts.
REQ-035 SHALL, if rst=1 mid-frame (any state), abandon the frame with no further mem_we pulse, including a pulse pending from the last accepted byte.
REQ-036 SHALL give rst priority over start and over a byte accepted in the same cycle.

Verification
REQ-037 SHALL verify single word: stream 01,00,33,E2,62,00,77 -> one mem_we with mem_addr=0, mem_wd=0x0062E233; then done=1, core_rst_n=1.
REQ-038 SHALL verify bad checksum: same stream with checksum 78 -> mem_we still pulses once; then err=1, core_rst_n=0, in_ready=0.
REQ-039 SHALL verify empty load: stream 00,00,00 -> no mem_we; DONE reached after 3 bytes.
REQ-040 SHALL verify oversize: N=0x0401 with DEPTH=1024 -> ERR after the 2nd byte; no mem_we.
REQ-041 SHALL verify throttled stream: 3 words with random in_valid gaps -> addresses 0, 4, 8 in order, data matches, done=1.
REQ-042 SHALL verify rst asserted after the 6th data byte, then a full new 1-word frame -> only the new word is written, at address 0.
